// File: rtl/dmem_chk_pkg.sv
// dmem_chk_pkg: state and fail-code encodings plus width helpers shared by the
// data-memory write checker and its expected-store table.
package dmem_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } chk_state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISMATCH = 2'd1,
    FC_MISSING  = 2'd2,
    FC_TIMEOUT  = 2'd3
  } fail_code_e;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dmem_chk_table.sv
// dmem_chk_table: expected (addr, data) store table with valid/matched bits and
// the match search (lowest free entry for any-order, read pointer for ordered).
module dmem_chk_table
  import dmem_chk_pkg::*;
#(
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned ADDR_W  = 32,
  parameter  int unsigned DEPTH   = 64,
  parameter  bit          ORDERED = 1'b0,
  localparam int unsigned IDX_W   = idx_width(DEPTH),
  localparam int unsigned CNT_W   = cnt_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] qry_addr_i,
  input  logic [DATA_W-1:0] qry_data_i,
  input  logic              consume_i,
  output logic              hit_o,
  output logic [CNT_W-1:0]  valid_cnt_o
);

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  matched_q, matched_d;
  logic [IDX_W:0]    rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0]  cand;
  logic              hit;
  logic [IDX_W-1:0]  hit_idx;

  // Payload has no reset: it is only ever observed through valid_q.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      addr_mem_q[wr_idx_i] <= wr_addr_i;
      data_mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_comb begin
    cand = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = valid_q[i] && !matched_q[i] &&
                (addr_mem_q[i] == qry_addr_i) && (data_mem_q[i] == qry_data_i);
    end
  end

  // Ordered mode stops matching once the pointer runs past the last entry.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    if (ORDERED) begin
      hit_idx = rd_ptr_q[IDX_W-1:0];
      hit     = !rd_ptr_q[IDX_W] && cand[hit_idx];
    end else begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (cand[i]) begin
          hit     = 1'b1;
          hit_idx = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    valid_d   = valid_q;
    matched_d = matched_q;
    rd_ptr_d  = rd_ptr_q;
    if (wr_en_i) begin
      valid_d[wr_idx_i] = 1'b1;
    end
    if (clr_i) begin
      matched_d = '0;
      rd_ptr_d  = '0;
    end else if (consume_i && hit) begin
      matched_d[hit_idx] = 1'b1;
      if (ORDERED) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_comb begin
    valid_cnt_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_cnt_o = valid_cnt_o + CNT_W'(valid_q[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= '0;
      matched_q <= '0;
      rd_ptr_q  <= '0;
    end else begin
      valid_q   <= valid_d;
      matched_q <= matched_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  assign hit_o = hit;

endmodule

// File: rtl/dmem_wr_checker.sv
// dmem_wr_checker: self-check monitor on the core's data-memory write bus.
// Optional watchdog built in when DMEM_CHK_TIMEOUT_EN is defined.
module dmem_wr_checker
  import dmem_chk_pkg::*;
#(
  parameter int unsigned MP_DATA_WIDTH = 32,
  parameter int unsigned MP_ADDR_WIDTH = 32,
  parameter int unsigned MP_DEPTH      = 64,
  parameter int unsigned MP_ORDERED    = 0,
  parameter int unsigned MP_IGN_LO     = 96,
  parameter int unsigned MP_IGN_HI     = 99,
  parameter int unsigned MP_END_ADDR   = 40,
  parameter int unsigned MP_END_DATA   = 30,
  parameter int unsigned MP_TIMEOUT    = 100000
) (
  input  logic                               iclk,
  input  logic                               irst_n,
  input  logic                               istart,
  input  logic                               iexp_we,
  input  logic [idx_width(MP_DEPTH)-1:0]     iexp_idx,
  input  logic [MP_ADDR_WIDTH-1:0]           iexp_addr,
  input  logic [MP_DATA_WIDTH-1:0]           iexp_data,
  input  logic                               idmem_wr_en,
  input  logic [MP_ADDR_WIDTH-1:0]           idmem_addr,
  input  logic [MP_DATA_WIDTH-1:0]           idmem_wr_data,
  output logic [1:0]                         ostate,
  output logic [cnt_width(MP_DEPTH)-1:0]     opass_cnt,
  output logic [1:0]                         ofail_code,
  output logic [MP_ADDR_WIDTH-1:0]           ofail_addr,
  output logic [MP_DATA_WIDTH-1:0]           ofail_data
);

  localparam int unsigned CNT_W = cnt_width(MP_DEPTH);
  localparam logic [CNT_W-1:0]         CNT_MAX  = CNT_W'(MP_DEPTH);
  localparam logic [MP_ADDR_WIDTH-1:0] IGN_LO   = MP_ADDR_WIDTH'(MP_IGN_LO);
  localparam logic [MP_ADDR_WIDTH-1:0] IGN_HI   = MP_ADDR_WIDTH'(MP_IGN_HI);
  localparam logic [MP_ADDR_WIDTH-1:0] END_ADDR = MP_ADDR_WIDTH'(MP_END_ADDR);
  localparam logic [MP_DATA_WIDTH-1:0] END_DATA = MP_DATA_WIDTH'(MP_END_DATA);

  chk_state_e                 state_q, state_d;
  fail_code_e                 fail_code_q, fail_code_d;
  logic [CNT_W-1:0]           pass_cnt_q, pass_cnt_d;
  logic [MP_ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
  logic [MP_DATA_WIDTH-1:0]   fail_data_q, fail_data_d;
  logic                       running, start_acc, tbl_we;
  logic                       in_ign, is_end, hit, consume;
  logic [CNT_W-1:0]           valid_cnt;

`ifdef DMEM_CHK_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(MP_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MP_TIMEOUT);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`else
  // MP_TIMEOUT only matters when the watchdog is built in.
  logic unused_tmo;
  assign unused_tmo = ^MP_TIMEOUT;
`endif

  assign running   = (state_q == ST_RUN);
  assign start_acc = istart && !running;
  assign tbl_we    = iexp_we && !running;
  assign in_ign    = (idmem_addr >= IGN_LO) && (idmem_addr <= IGN_HI);
  assign is_end    = (idmem_addr == END_ADDR) && (idmem_wr_data == END_DATA);

  dmem_chk_table #(
    .DATA_W  (MP_DATA_WIDTH),
    .ADDR_W  (MP_ADDR_WIDTH),
    .DEPTH   (MP_DEPTH),
    .ORDERED (MP_ORDERED != 0)
  ) u_table (
    .clk_i       (iclk),
    .rst_ni      (irst_n),
    .wr_en_i     (tbl_we),
    .wr_idx_i    (iexp_idx),
    .wr_addr_i   (iexp_addr),
    .wr_data_i   (iexp_data),
    .clr_i       (start_acc),
    .qry_addr_i  (idmem_addr),
    .qry_data_i  (idmem_wr_data),
    .consume_i   (consume),
    .hit_o       (hit),
    .valid_cnt_o (valid_cnt)
  );

  // Store priority in RUN: ignore window, table match, terminator, mismatch.
  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    pass_cnt_d  = pass_cnt_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    consume     = 1'b0;
`ifdef DMEM_CHK_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif
    unique case (state_q)
      ST_RUN: begin
`ifdef DMEM_CHK_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        if (idmem_wr_en && !in_ign) begin
          if (hit) begin
            consume = 1'b1;
            if (pass_cnt_q != CNT_MAX) begin
              pass_cnt_d = pass_cnt_q + 1'b1;
            end
          end else if (is_end) begin
            if (pass_cnt_q == valid_cnt) begin
              state_d = ST_PASS;
            end else begin
              state_d     = ST_FAIL;
              fail_code_d = FC_MISSING;
            end
          end else begin
            state_d     = ST_FAIL;
            fail_code_d = FC_MISMATCH;
            fail_addr_d = idmem_addr;
            fail_data_d = idmem_wr_data;
          end
        end
`ifdef DMEM_CHK_TIMEOUT_EN
        // A store landing on the expiry cycle has already settled the verdict.
        if ((state_d == ST_RUN) && (tmo_cnt_d == TMO_LIMIT)) begin
          state_d     = ST_FAIL;
          fail_code_d = FC_TIMEOUT;
          fail_addr_d = '0;
          fail_data_d = '0;
        end
`endif
      end
      default: begin
        if (istart) begin
          state_d     = ST_RUN;
          fail_code_d = FC_NONE;
          pass_cnt_d  = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
`ifdef DMEM_CHK_TIMEOUT_EN
          tmo_cnt_d   = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q     <= ST_IDLE;
      fail_code_q <= FC_NONE;
      pass_cnt_q  <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
`ifdef DMEM_CHK_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      fail_code_q <= fail_code_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
`ifdef DMEM_CHK_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign ostate     = state_q;
  assign opass_cnt  = pass_cnt_q;
  assign ofail_code = fail_code_q;
  assign ofail_addr = fail_addr_q;
  assign ofail_data = fail_data_q;

endmodule
